// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared types and helpers for the multi-channel blinker
//
// Contents:
//   mode_t        2-bit channel mode: OFF, ON, continuous BLINK, N-period BURST
//   starts_active whether a freshly written channel begins running its counter
package blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_t;

  // A BURST of zero periods never runs; it just reports done on the next edge.
  function automatic logic starts_active(input mode_t m, input logic burst_nonzero);
    return (m == MODE_BLINK) || ((m == MODE_BURST) && burst_nonzero);
  endfunction

endpackage

// File: rtl/blink_chan.sv
// rtl/blink_chan.sv - one blinker channel: period/duty counter with burst tracking
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   we          write strobe for this channel (already decoded by the top)
//   mode_in     mode to latch on write
//   period_in   period length minus one (P)
//   duty_in     high cycles per period (D)
//   burst_in    periods to run in BURST mode (N)
//   led         registered LED output
//   flg         registered one-cycle strobe at the start of each period
//   done        registered burst-complete level
module blink_chan
  import blink_pkg::*;
#(
  parameter int CBITS = 20,
  parameter int BBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  mode_t            mode_in,
  input  logic [CBITS-1:0] period_in,
  input  logic [CBITS-1:0] duty_in,
  input  logic [BBITS-1:0] burst_in,
  output logic             led,
  output logic             flg,
  output logic             done
);

  mode_t            mode;
  logic [CBITS-1:0] per;
  logic [CBITS-1:0] duty;
  logic [BBITS-1:0] rem;
  logic [CBITS-1:0] cnt;
  logic             active;

  logic             at_wrap;
  logic             last_period;

  assign at_wrap     = (cnt == per);
  assign last_period = (rem == BBITS'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mode   <= MODE_OFF;
      per    <= '0;
      duty   <= '0;
      rem    <= '0;
      cnt    <= '0;
      active <= 1'b0;
      led    <= 1'b0;
      flg    <= 1'b0;
      done   <= 1'b0;
    end else if (we) begin
      // A write restarts the channel from a clean state; the first period
      // begins on the following edge.
      mode   <= mode_in;
      per    <= period_in;
      duty   <= duty_in;
      rem    <= burst_in;
      cnt    <= '0;
      active <= starts_active(mode_in, burst_in != '0);
      led    <= 1'b0;
      flg    <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (mode)
        MODE_OFF: begin
          led <= 1'b0;
          flg <= 1'b0;
        end
        MODE_ON: begin
          led <= 1'b1;
          flg <= 1'b0;
        end
        MODE_BLINK, MODE_BURST: begin
          if (active) begin
            led <= (cnt < duty);
            flg <= (cnt == '0);
            cnt <= at_wrap ? '0 : cnt + CBITS'(1);
            if ((mode == MODE_BURST) && at_wrap) begin
              if (last_period) begin
                active <= 1'b0;
                done   <= 1'b1;
                rem    <= '0;
              end else begin
                rem <= rem - BBITS'(1);
              end
            end
          end else begin
            // Finished (or zero-length) burst: dark and quiet until rewritten.
            // This also covers N=0, which reports done one edge after the write.
            led <= 1'b0;
            flg <= 1'b0;
            if (mode == MODE_BURST) begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          led <= 1'b0;
          flg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/blink_multi.sv
// rtl/blink_multi.sv - NCH-channel status blinker with runtime period/duty/mode
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset (wins over cfg_we)
//   cfg_we      one-cycle config write strobe
//   cfg_ch      target channel; values at or above NCH are ignored
//   cfg_mode    0 OFF, 1 ON, 2 BLINK, 3 BURST
//   cfg_period  period length minus one
//   cfg_duty    high cycles per period
//   cfg_burst   number of periods in BURST mode
//   led         per-channel LED, registered
//   flg         per-channel period-start strobe, registered
//   done        per-channel burst-complete level, registered
module blink_multi
  import blink_pkg::*;
#(
  parameter int CBITS = 20,
  parameter int NCH   = 4,
  parameter int BBITS = 4,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CBITS-1:0] cfg_period,
  input  logic [CBITS-1:0] cfg_duty,
  input  logic [BBITS-1:0] cfg_burst,
  output logic [NCH-1:0]   led,
  output logic [NCH-1:0]   flg,
  output logic [NCH-1:0]   done
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic we_ch;

    // Out-of-range channel numbers match no instance and are dropped here.
    assign we_ch = cfg_we && (cfg_ch == CHW'(i));

    blink_chan #(
      .CBITS(CBITS),
      .BBITS(BBITS)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .we       (we_ch),
      .mode_in  (mode_t'(cfg_mode)),
      .period_in(cfg_period),
      .duty_in  (cfg_duty),
      .burst_in (cfg_burst),
      .led      (led[i]),
      .flg      (flg[i]),
      .done     (done[i])
    );
  end

endmodule

// File: tb/tb_blink_multi.sv
// tb/tb_blink_multi.sv - self-checking bench for blink_multi against a timing-rule model
module tb_blink_multi;

  localparam int CBITS = 20;
  localparam int NCH   = 3;
  localparam int BBITS = 4;
  localparam int CHW   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CBITS-1:0] cfg_period;
  logic [CBITS-1:0] cfg_duty;
  logic [BBITS-1:0] cfg_burst;
  logic [NCH-1:0]   led;
  logic [NCH-1:0]   flg;
  logic [NCH-1:0]   done;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  // Model: what was last written to each channel and at which edge.
  int m_mode [NCH];
  int m_p    [NCH];
  int m_d    [NCH];
  int m_n    [NCH];
  int m_k    [NCH];

  blink_multi #(.CBITS(CBITS), .NCH(NCH), .BBITS(BBITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_period(cfg_period),
    .cfg_duty  (cfg_duty),
    .cfg_burst (cfg_burst),
    .led       (led),
    .flg       (flg),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0; m_p[c] = 0; m_d[c] = 0; m_n[c] = 0; m_k[c] = edge_n;
    end
  endfunction

  // Expected {led, flg, done} for channel ch after edge t, from the timing rules:
  // period-relative position (e-1) mod (P+1), N periods then done.
  function automatic logic [2:0] model(int ch, int t);
    int e;
    int pos;
    int total;
    e = t - m_k[ch];
    if (e < 1) return 3'b000;
    case (m_mode[ch])
      1: return 3'b100;
      2: begin
        pos = (e - 1) % (m_p[ch] + 1);
        return {pos < m_d[ch], pos == 0, 1'b0};
      end
      3: begin
        if (m_n[ch] == 0) return 3'b001;
        total = m_n[ch] * (m_p[ch] + 1);
        if (e > total) return 3'b001;
        pos = (e - 1) % (m_p[ch] + 1);
        return {pos < m_d[ch], pos == 0, e == total};
      end
      default: return 3'b000;
    endcase
  endfunction

  // Drive one config write across one edge and update the model.
  task automatic cfg(int ch, int mode, int p, int d, int n);
    cfg_we     = 1'b1;
    cfg_ch     = CHW'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = CBITS'(p);
    cfg_duty   = CBITS'(d);
    cfg_burst  = BBITS'(n);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (rst) model_reset();
    else if (ch < NCH) begin
      m_mode[ch] = mode; m_p[ch] = p; m_d[ch] = d; m_n[ch] = n; m_k[ch] = edge_n;
    end
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    logic [2:0] got;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({led, flg, done} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle edge %0d got led=%b flg=%b done=%b exp all 0", edge_n, led, flg, done);
      end
      for (int ch = 0; ch < NCH; ch++) begin
        exp = model(ch, edge_n); got = {led[ch], flg[ch], done[ch]}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_model ch%0d edge %0d got %b exp %b", ch, edge_n, got, exp); end
      end
    end
  endtask

  task automatic test_blink();
    logic [3:0] pat;
    logic [2:0] exp;
    logic [2:0] got;
    int e;
    pat = 4'b1100;
    cfg(0, 2, 3, 2, 0);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      e = edge_n - m_k[0];
      n_tests++;
      if (led[0] !== pat[3 - ((e - 1) % 4)] || flg[0] !== ((e - 1) % 4 == 0)) begin
        n_fail++;
        $display("FAIL blink_pattern e=%0d got led=%b flg=%b", e, led[0], flg[0]);
      end
      for (int ch = 0; ch < NCH; ch++) begin
        exp = model(ch, edge_n); got = {led[ch], flg[ch], done[ch]}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL blink ch%0d edge %0d got %b exp %b", ch, edge_n, got, exp); end
      end
    end
  endtask

  task automatic test_burst();
    logic [2:0] exp;
    logic [2:0] got;
    int pulses;
    int rise_e;
    pulses = 0;
    rise_e = -1;
    cfg(1, 3, 4, 1, 3);
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (flg[1]) pulses++;
      if (done[1] && rise_e < 0) rise_e = edge_n - m_k[1];
      for (int ch = 0; ch < NCH; ch++) begin
        exp = model(ch, edge_n); got = {led[ch], flg[ch], done[ch]}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL burst ch%0d edge %0d got %b exp %b", ch, edge_n, got, exp); end
      end
    end
    n_tests++;
    if (pulses !== 3) begin n_fail++; $display("FAIL burst_pulses got %0d exp 3", pulses); end
    n_tests++;
    if (rise_e !== 15) begin n_fail++; $display("FAIL burst_done_time got %0d exp 15", rise_e); end
    cfg(1, 3, 4, 1, 0);
    n_tests++;
    if (done[1] !== 1'b0) begin n_fail++; $display("FAIL burst_n0_write got done=%b exp 0", done[1]); end
    @(posedge clk); #1;
    n_tests++;
    if ({led[1], flg[1], done[1]} !== 3'b001) begin
      n_fail++; $display("FAIL burst_n0 got %b exp 001", {led[1], flg[1], done[1]});
    end
  endtask

  task automatic test_bounds();
    logic [2:0] exp;
    logic [2:0] got;
    int cases [5][4] = '{'{2, 0, 1, 6}, '{2, 3, 0, 6}, '{2, 3, 9, 8}, '{1, 3, 1, 4}, '{0, 3, 1, 4}};
    for (int k = 0; k < 5; k++) begin
      cfg(2, cases[k][0], cases[k][1], cases[k][2], 0);
      for (int c = 0; c < cases[k][3]; c++) begin
        @(posedge clk); #1;
        for (int ch = 0; ch < NCH; ch++) begin
          exp = model(ch, edge_n); got = {led[ch], flg[ch], done[ch]}; n_tests++;
          if (got !== exp) begin n_fail++; $display("FAIL bounds%0d ch%0d edge %0d got %b exp %b", k, ch, edge_n, got, exp); end
        end
      end
    end
    cfg(2, 2, 0, 1, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++;
    if ({led[2], flg[2]} !== 2'b11) begin n_fail++; $display("FAIL bounds_p0 got %b exp 11", {led[2], flg[2]}); end
  endtask

  task automatic test_midop();
    logic [2:0] exp;
    logic [2:0] got;
    cfg(0, 2, 3, 2, 0);
    repeat (2) begin @(posedge clk); #1; end
    cfg(0, 2, 7, 3, 0);
    n_tests++;
    if ({led[0], flg[0]} !== 2'b00) begin n_fail++; $display("FAIL midop_write got %b exp 00", {led[0], flg[0]}); end
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      for (int ch = 0; ch < NCH; ch++) begin
        exp = model(ch, edge_n); got = {led[ch], flg[ch], done[ch]}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL midop ch%0d edge %0d got %b exp %b", ch, edge_n, got, exp); end
      end
    end
    cfg(1, 3, 4, 2, 3);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    n_tests++;
    if ({led, flg, done} !== '0) begin
      n_fail++; $display("FAIL midop_reset got led=%b flg=%b done=%b exp 0", led, flg, done);
    end
  endtask

  task automatic test_out_of_range();
    logic [2:0] exp;
    logic [2:0] got;
    cfg(0, 2, 2, 1, 0);
    cfg(1, 1, 0, 0, 0);
    cfg(2, 3, 1, 1, 2);
    repeat (2) begin @(posedge clk); #1; end
    cfg(NCH, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      for (int ch = 0; ch < NCH; ch++) begin
        exp = model(ch, edge_n); got = {led[ch], flg[ch], done[ch]}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL out_of_range ch%0d edge %0d got %b exp %b", ch, edge_n, got, exp); end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] exp;
    logic [2:0] got;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 99) < 3) begin
        rst = 1'b1;
        if ($urandom_range(0, 1) == 1) cfg(int'($urandom_range(0, NCH - 1)), 2, 1, 1, 0);
        else begin @(posedge clk); #1; model_reset(); end
        rst = 1'b0;
      end else if ($urandom_range(0, 99) < 15) begin
        cfg(int'($urandom_range(0, NCH)), int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
            int'($urandom_range(0, 8)), int'($urandom_range(0, 3)));
      end else begin
        @(posedge clk); #1;
      end
      for (int ch = 0; ch < NCH; ch++) begin
        exp = model(ch, edge_n); got = {led[ch], flg[ch], done[ch]}; n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL random ch%0d edge %0d got %b exp %b", ch, edge_n, got, exp); end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_mode   = '0;
    cfg_period = '0;
    cfg_duty   = '0;
    cfg_burst  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    test_reset();
    test_blink();
    test_burst();
    test_bounds();
    test_midop();
    test_out_of_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
